muldiv_seq: RTL

Iterative multiply/divide sequencer for the MIPS core's HI/LO unit. It executes `mult`, `multu`, `div`, `divu`, `mthi` and `mtlo`, issued by the decode stage. It runs a 32-iteration shift-add multiply or a restoring divide on one shared adder, and owns the architectural HI/LO registers. It asserts a stall toward the pipeline when a new HI/LO operation or an `mfhi`/`mflo` read arrives while an operation is in flight.

---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/muldiv_step.sv | 34 +++
 rtl/muldiv_seq.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MTLO  = 6'h13;

  // Iteration counter width; covers WIDTH up to 64.
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FIXUP = 2'd2
  } state_e;

  // True for the four iterative operations (not mthi/mtlo).
  function automatic logic is_muldiv(input logic [5:0] f);
    return (f == FN_MULT) || (f == FN_MULTU) || (f == FN_DIV) || (f == FN_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add multiply or
// restoring-divide trial subtract over the 2*WIDTH accumulator.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic                 div_i,
  input  logic [2*WIDTH-1:0]   acc_i,
  input  logic [WIDTH-1:0]     opnd_i,
  output logic [2*WIDTH-1:0]   acc_o
);

  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       trial;
  logic [2*WIDTH-1:0]   shl;

  // Multiply: conditional add into the upper half then shift right, keeping
  // the carry. Divide: shift left, subtract using the bit shifted out as the
  // MSB of the partial remainder, keep the difference when it does not borrow.
  always_comb begin
    sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : {(WIDTH+1){1'b0}});
    shl   = {acc_i[2*WIDTH-2:0], 1'b0};
    trial = {acc_i[2*WIDTH-1], shl[2*WIDTH-1:WIDTH]} - {1'b0, opnd_i};
    if (div_i) begin
      if (!trial[WIDTH]) begin
        acc_o = {trial[WIDTH-1:0], shl[WIDTH-1:1], 1'b1};
      end else begin
        acc_o = shl;
      end
    end else begin
      acc_o = {sum, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide sequencer owning the architectural HI/LO
// registers. Signed operations run on magnitudes and are sign-corrected in
// a single FIXUP cycle before the commit.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [5:0]       Funct,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  input  logic             ReqRead,
  input  logic             Cancel,
  output logic             Busy,
  output logic             Stall,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic                 div_q, div_d;
  logic                 neg_q, neg_d;
  logic                 rem_neg_q, rem_neg_d;
  logic                 dz_q, dz_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;

  logic                 op_signed, op_div;
  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [2*WIDTH-1:0]   acc_step;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     quo, rem;

  assign op_signed = (Funct == FN_MULT) || (Funct == FN_DIV);
  assign op_div    = (Funct == FN_DIV) || (Funct == FN_DIVU);
  assign a_neg     = op_signed & OpA[WIDTH-1];
  assign b_neg     = op_signed & OpB[WIDTH-1];
  assign a_mag     = a_neg ? (~OpA + 1'b1) : OpA;
  assign b_mag     = b_neg ? (~OpB + 1'b1) : OpB;

  assign Busy  = (state_q != ST_IDLE);
  assign Stall = Busy & (Start | ReqRead);
  assign Done  = done_q;
  assign Hi    = hi_q;
  assign Lo    = lo_q;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div_i  (div_q),
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .acc_o  (acc_step)
  );

  // Sign correction of the magnitude result, used only in FIXUP.
  always_comb begin
    prod = neg_q ? (~acc_q + 1'b1) : acc_q;
    quo  = neg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    rem  = rem_neg_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
  end

  // Next-state and datapath updates; Cancel overrides everything but reset.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    div_d     = div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    if (Cancel) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Start) begin
            if (is_muldiv(Funct)) begin
              div_d     = op_div;
              neg_d     = a_neg ^ b_neg;
              rem_neg_d = a_neg;
              dz_d      = op_div && (OpB == '0);
              cnt_d     = '0;
              if (op_div && (OpB == '0)) begin
                acc_d   = {{WIDTH{1'b0}}, OpA};
                state_d = ST_FIXUP;
              end else if (op_div) begin
                acc_d   = {{WIDTH{1'b0}}, a_mag};
                opnd_d  = b_mag;
                state_d = ST_RUN;
              end else begin
                acc_d   = {{WIDTH{1'b0}}, b_mag};
                opnd_d  = a_mag;
                state_d = ST_RUN;
              end
            end else if (Funct == FN_MTHI) begin
              hi_d = OpA;
            end else if (Funct == FN_MTLO) begin
              lo_d = OpA;
            end
          end
        end
        ST_RUN: begin
          acc_d = acc_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d = ST_FIXUP;
          end
        end
        ST_FIXUP: begin
          if (dz_q) begin
            hi_d = acc_q[WIDTH-1:0];
            lo_d = '1;
          end else if (div_q) begin
            hi_d = rem;
            lo_d = quo;
          end else begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, datapath and HI/LO registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      div_q     <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      div_q     <= div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

endmodule
